// File: rtl/iob_iob2wishbone_pkg.sv
// Shared definitions for the IOb-to-Wishbone bridge: FSM encoding,
// error read fill value and default watchdog width.
package iob_iob2wishbone_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam int   TIMEOUT_W_DEF = 8;

    // Every bit of the read data returned for an aborted read takes this value.
    localparam logic ERR_RDATA_BIT = 1'b1;

endpackage

// File: rtl/iob_iob2wishbone_wdog.sv
// Bus-cycle watchdog: down-counter loaded with all-ones on clear, terminal
// count flags the last BUS cycle allowed before the cycle is aborted.
module iob_iob2wishbone_wdog
    import iob_iob2wishbone_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '1;
        end else if (clr_i) begin
            cnt <= '1;
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Count 1 means the edge ending this cycle is the (2^W-1)-th BUS edge.
    assign tc_o = (cnt == TIMEOUT_W'(1));

endmodule

// File: rtl/iob_iob2wishbone.sv
// IOb slave to Wishbone classic master bridge, one outstanding request,
// read data returned as a single-cycle rvalid pulse; errors on err_o.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a new IOb request, Wishbone cycle inactive
// ST_BUS  | Wishbone cycle in progress, waiting for ack, err or timeout
module iob_iob2wishbone
    import iob_iob2wishbone_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic                err_o
);

    localparam int STRB_W = DATA_W / 8;

    state_t state, state_nxt;
    logic   accept;
    logic   bus_end;
    logic   bus_fail;
    logic   wd_tc;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        iob_ready_o = 1'b0;
        accept      = 1'b0;
        bus_end     = 1'b0;
        bus_fail    = 1'b0;
        case (state)
            ST_IDLE: begin
                iob_ready_o = rst_n_i;
                accept      = iob_avalid_i & rst_n_i & cke_i;
                if (accept) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                // err beats ack, ack beats a timeout in the same cycle
                bus_end  = wb_err_i | wb_ack_i | wd_tc;
                bus_fail = wb_err_i | (wd_tc & ~wb_ack_i);
                if (bus_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
            err_o        <= 1'b0;
        end else if (cke_i) begin
            iob_rvalid_o <= 1'b0;
            err_o        <= 1'b0;
            if (accept) begin
                wb_adr_o <= iob_addr_i;
                wb_dat_o <= iob_wdata_i;
                wb_we_o  <= |iob_wstrb_i;
                wb_sel_o <= (|iob_wstrb_i) ? iob_wstrb_i : {STRB_W{1'b1}};
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end
            if (bus_end) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                err_o    <= bus_fail;
                if (!wb_we_o) begin
                    iob_rvalid_o <= 1'b1;
                    iob_rdata_o  <= bus_fail ? {DATA_W{ERR_RDATA_BIT}} : wb_dat_i;
                end
            end
        end
    end

    iob_iob2wishbone_wdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (accept),
        .en_i    (cke_i & (state == ST_BUS)),
        .tc_o    (wd_tc)
    );

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// Scoreboard bench for the IOb-to-Wishbone bridge: driver pushes expected
// responses, a Wishbone slave model answers, a monitor pops and compares.
module tb_iob_iob2wishbone;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TW  = 4;
    localparam int TMO = (1 << TW) - 1;

    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_TMO   = 3;
    localparam int K_ABORT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cke = 1'b1;
    logic          avalid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          iob_ready_o;
    logic          iob_rvalid_o;
    logic [DW-1:0] iob_rdata_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [DW-1:0] wb_dat_in = '0;
    logic          wb_ack = 1'b0;
    logic          wb_err = 1'b0;
    logic          err_o;

    always #5 clk = ~clk;

    iob_iob2wishbone #(
        .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_W (TW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cke_i        (cke),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_ready_o  (iob_ready_o),
        .iob_rvalid_o (iob_rvalid_o),
        .iob_rdata_o  (iob_rdata_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_we_o      (wb_we_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_dat_i     (wb_dat_in),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err),
        .err_o        (err_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            kind;
        int            lat;
        logic [DW-1:0] sdata;
        int            extra;
    } plan_t;

    typedef struct {
        logic          rvalid;
        logic          err;
        logic [DW-1:0] rdata;
        int            len;
        bit            abort;
    } want_t;

    plan_t slave_q[$];
    want_t want_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic plan_t mk(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] ws, input int kind, input int lat,
                                 input logic [DW-1:0] sd, input int extra);
        plan_t p;
        p.addr = a; p.wdata = wd; p.wstrb = ws; p.kind = kind;
        p.lat = lat; p.sdata = sd; p.extra = extra;
        return p;
    endfunction

    // Expected IOb-side outcome derived from what the slave model will do.
    function automatic want_t expect_of(input plan_t p);
        want_t w;
        w.abort  = (p.kind == K_ABORT);
        w.rvalid = (p.wstrb == '0) && !w.abort;
        w.err    = (p.kind == K_ERR) || (p.kind == K_BOTH) || (p.kind == K_TMO);
        w.rdata  = (p.kind == K_ACK) ? p.sdata : {DW{1'b1}};
        w.len    = (p.kind == K_TMO) ? TMO : p.lat + p.extra;
        return w;
    endfunction

    task automatic issue(input plan_t p, output int waited);
        int n;
        n = 0;
        while (iob_ready_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (iob_ready_o !== 1'b1) begin
            chk("ready_wait_timeout", iob_ready_o, 1);
            return;
        end
        avalid = 1'b1;
        addr   = p.addr;
        wdata  = p.wdata;
        wstrb  = p.wstrb;
        slave_q.push_back(p);
        want_q.push_back(expect_of(p));
        @(negedge clk);
        avalid = 1'b0;
        addr   = $urandom;
        wdata  = $urandom;
        wstrb  = SW'($urandom);
        chk("cyc_stb_after_accept", {wb_cyc_o, wb_stb_o}, 2'b11);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((want_q.size() != 0 || wb_cyc_o === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", want_q.size(), 0);
    endtask

    // Wishbone slave model: answers each cycle according to its plan.
    initial begin
        plan_t cur;
        bit    active;
        int    bc;
        active = 0;
        bc = 0;
        forever begin
            @(negedge clk);
            wb_dat_in = $urandom;
            if (wb_cyc_o === 1'b1) begin
                if (!active) begin
                    if (slave_q.size() == 0) begin
                        chk("unexpected_cycle", wb_cyc_o, 0);
                    end else begin
                        cur = slave_q.pop_front();
                        active = 1;
                        bc = 0;
                    end
                end
                if (active) begin
                    bc++;
                    chk("wb_adr", wb_adr_o, cur.addr);
                    chk("wb_we", wb_we_o, (cur.wstrb != '0));
                    chk("wb_sel", wb_sel_o, (cur.wstrb == '0) ? {SW{1'b1}} : cur.wstrb);
                    if (cur.wstrb != '0) chk("wb_dat", wb_dat_o, cur.wdata);
                    chk("wb_stb", wb_stb_o, 1);
                    chk("ready_in_bus", iob_ready_o, 0);
                    wb_ack = ((cur.kind == K_ACK) || (cur.kind == K_BOTH)) && (bc >= cur.lat);
                    wb_err = ((cur.kind == K_ERR) || (cur.kind == K_BOTH)) && (bc >= cur.lat);
                    if (wb_ack && cur.wstrb == '0) wb_dat_in = cur.sdata;
                end
            end else begin
                active = 0;
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end
        end
    end

    // Monitor: a transaction ends when cyc falls; pulses at any other time are spurious.
    initial begin
        bit            prev;
        int            len;
        logic [DW-1:0] last;
        want_t         w;
        prev = 0;
        len  = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (prev && wb_cyc_o !== 1'b1) begin
                if (want_q.size() == 0) begin
                    chk("unexpected_end", wb_cyc_o, 1);
                end else begin
                    w = want_q.pop_front();
                    chk("rvalid", iob_rvalid_o, w.rvalid);
                    chk("err_o", err_o, w.err);
                    if (w.abort) begin
                        chk("rdata_after_reset", iob_rdata_o, 0);
                        last = '0;
                    end else begin
                        chk("cyc_len", len, w.len);
                        if (w.rvalid) begin
                            chk("rdata", iob_rdata_o, w.rdata);
                            last = w.rdata;
                        end else begin
                            chk("rdata_hold", iob_rdata_o, last);
                        end
                    end
                end
            end else if (iob_rvalid_o === 1'b1 || err_o === 1'b1) begin
                chk("spurious_pulse", {iob_rvalid_o, err_o}, 0);
            end
            if (wb_cyc_o === 1'b1) len = prev ? len + 1 : 1;
            prev = (wb_cyc_o === 1'b1);
        end
    end

    initial begin
        int w;
        int n;
        int kind;
        logic [SW-1:0] ws;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", iob_ready_o, 0);
        chk("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst_rvalid_err", {iob_rvalid_o, err_o}, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rdata", iob_rdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", iob_ready_o, 1);

        issue(mk(32'h10, 32'h0, 4'h0, K_ACK, 1, 32'hA5A5_0001, 0), w);
        issue(mk(32'h04, 32'h0000_00C3, 4'h1, K_ACK, 4, 32'h0, 0), w);
        wait_idle();

        issue(mk(32'h00, 32'h1234_5678, 4'h0, K_ACK, 1, 32'h0BAD_F00D, 0), w);
        issue(mk(32'h08, 32'hCAFE_0008, 4'hF, K_ACK, 1, 32'h0, 0), w);
        chk("back_to_back_wait", w, 1);
        wait_idle();

        issue(mk(32'h20, 32'h0, 4'h0, K_ERR, 2, 32'h1111_2222, 0), w);
        issue(mk(32'h24, 32'h0, 4'h0, K_TMO, 1, 32'h0, 0), w);
        issue(mk(32'h28, 32'h5555_AAAA, 4'h6, K_TMO, 1, 32'h0, 0), w);
        issue(mk(32'h2C, 32'h0, 4'h0, K_BOTH, 3, 32'h3333_4444, 0), w);
        issue(mk(32'h30, 32'h7777_8888, 4'hC, K_ERR, 1, 32'h0, 0), w);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 99);
            kind = (n < 60) ? K_ACK : (n < 75) ? K_ERR : (n < 88) ? K_BOTH : K_TMO;
            ws = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom_range(1, (1 << SW) - 1));
            issue(mk($urandom, $urandom, ws, kind, $urandom_range(1, 6), $urandom, 0), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Clock enable held low for five cycles while ack is presented.
        issue(mk(32'h40, 32'h0, 4'h0, K_ACK, 2, 32'hDEAD_BEEF, 5), w);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (wb_ack !== 1'b1 && n < 20);
        cke = 1'b0;
        repeat (5) @(negedge clk);
        chk("cyc_frozen_cke", wb_cyc_o, 1);
        cke = 1'b1;
        wait_idle();

        // Reset in the middle of a bus cycle aborts it silently.
        issue(mk(32'h50, 32'h9999_0000, 4'h3, K_ABORT, 1, 32'h0, 0), w);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", iob_ready_o, 0);
        chk("cyc_dropped_by_reset", {wb_cyc_o, wb_stb_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", iob_ready_o, 1);
        wait_idle();

        issue(mk(32'h60, 32'h0, 4'h0, K_ACK, 2, 32'h0F0F_F0F0, 0), w);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
